// File: rtl/freq_meter_if.sv
// Measurement control and result bundle for freq_meter.
// valid is a one-cycle strobe with no ready: meas_freq/overflow change only with it.
interface freq_meter_if;
    logic        f_in;
    logic        start;
    logic        cont;
    logic [31:0] meas_freq;
    logic        valid;
    logic        busy;
    logic        overflow;
    logic [1:0]  state;

    modport master (
        output f_in, start, cont,
        input  meas_freq, valid, busy, overflow, state
    );

    modport slave (
        input  f_in, start, cont,
        output meas_freq, valid, busy, overflow, state
    );
endinterface

// File: rtl/freq_meter.sv
// Gated-window frequency counter: counts synchronized f_in rising edges over
// GATE_CYCLES clk cycles and reports edges*SCALE in Hz, saturating at 32 bits.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 4_000_000,
    parameter int unsigned SCALE       = 1000
) (
    input logic         clk,
    input logic         rst,
    freq_meter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q, hist_q;
    logic        edge_pulse;
    logic [31:0] gate_q, gate_d;
    logic [31:0] edges_q, edges_d;
    logic [31:0] acc_q, acc_d;
    logic        acc_ovf_q, acc_ovf_d;
    logic [31:0] meas_q, meas_d;
    logic        ovf_q, ovf_d;
    logic [32:0] acc_sum;
    logic        launch;

    assign edge_pulse = sync2_q & ~hist_q;

    // The product is built by adding SCALE per edge, so no wide multiplier
    // sits in the path; the carry out marks the result as saturated.
    assign acc_sum = {1'b0, acc_q} + {1'b0, SCALE};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= 1'b0;
            gate_q    <= '0;
            edges_q   <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            meas_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= bus.f_in;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            gate_q    <= gate_d;
            edges_q   <= edges_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            meas_q    <= meas_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        edges_d   = edges_q;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        meas_d    = meas_q;
        ovf_d     = ovf_q;
        launch    = 1'b0;

        case (state_q)
            S_IDLE: launch = bus.start | bus.cont;
            S_GATE: begin
                gate_d = gate_q - 32'd1;
                if (edge_pulse) begin
                    if (edges_q != 32'hFFFF_FFFF) begin
                        edges_d = edges_q + 32'd1;
                    end
                    acc_d     = acc_sum[31:0];
                    acc_ovf_d = acc_ovf_q | acc_sum[32];
                end
                // Last gate cycle: the result includes this cycle's edge.
                if (gate_q == 32'd1) begin
                    state_d = S_DONE;
                    ovf_d   = acc_ovf_d | (edges_d == 32'hFFFF_FFFF);
                    meas_d  = ovf_d ? 32'hFFFF_FFFF : acc_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                launch  = bus.cont;
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d   = S_GATE;
            gate_d    = GATE_CYCLES;
            edges_d   = '0;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
        end
    end

    assign bus.meas_freq = meas_q;
    assign bus.overflow  = ovf_q;
    assign bus.valid     = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state     = state_q;
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: constant-expectation vector table, hand-written reset and
// ignored-start sequences, and random f_in checked against an edge-window model.
module tb_freq_meter;
    localparam int unsigned G_A  = 100;
    localparam int unsigned S_A  = 10;
    localparam int unsigned S_B  = 32'h4000_0000;
    localparam int unsigned G_C  = 20;
    localparam int unsigned S_C  = 1_100_000_000;
    localparam int          MAXC = 60000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    freq_meter_if if_a ();
    freq_meter_if if_b ();
    freq_meter_if if_c ();

    freq_meter #(.GATE_CYCLES(G_A), .SCALE(S_A)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    freq_meter #(.GATE_CYCLES(G_A), .SCALE(S_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    freq_meter #(.GATE_CYCLES(G_C), .SCALE(S_C)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit s_c [0:MAXC-1];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Index k of s_c holds the f_in level seen at posedge k.
    always @(posedge clk) begin
        if (cyc < MAXC) s_c[cyc] = if_c.f_in;
        cyc++;
    end

    // Shared periodic generator for instances a and b.
    int   gen_period = 0;
    int   gen_high   = 0;
    logic gen_level  = 1'b0;
    initial begin : gen_ab
        int   ph;
        logic v;
        ph = 0;
        forever begin
            @(negedge clk);
            if (gen_period == 0) v = gen_level;
            else begin
                v = ((ph % gen_period) < gen_high);
                ph++;
            end
            if_a.f_in = v;
            if_b.f_in = v;
        end
    end

    initial begin : gen_c
        int   hold;
        logic lvl;
        hold = 1;
        lvl  = 1'b0;
        forever begin
            @(negedge clk);
            hold--;
            if (hold == 0) begin
                lvl  = ~lvl;
                hold = $urandom_range(1, 5);
            end
            if_c.f_in = lvl;
        end
    end

    // A gate opened at posedge t sees a counted pulse for each j in [t, t+G)
    // where the level sampled at j-1 is high and the one at j-2 is low.
    function automatic logic [32:0] ref_c(input int t);
        longint unsigned edges;
        longint unsigned prod;
        edges = 0;
        for (int j = t; j < t + int'(G_C); j++) begin
            if (j >= 2 && s_c[j-1] && !s_c[j-2]) edges++;
        end
        prod = edges * longint'(S_C);
        if (prod > 64'hFFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, prod[31:0]};
    endfunction

    int          w_c;
    logic [32:0] r_c;
    always @(negedge clk) begin
        if (if_c.valid === 1'b1) begin
            if (exp_q.size() == 0) fail_now("c_spurious_valid");
            else begin
                w_c = int'(exp_q.pop_front());
                r_c = ref_c(w_c);
                check("c_valid_time", cyc, w_c + int'(G_C) + 1);
                check("c_meas", if_c.meas_freq, r_c[31:0]);
                check("c_ovf", if_c.overflow, r_c[32]);
            end
        end
    end

    task automatic set_start(input int w, input logic v);
        if (w == 0) if_a.start = v; else if_b.start = v;
    endtask
    task automatic set_cont(input int w, input logic v);
        if (w == 0) if_a.cont = v; else if_b.cont = v;
    endtask
    function automatic logic get_valid(input int w);
        return (w == 0) ? if_a.valid : if_b.valid;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? if_a.busy : if_b.busy;
    endfunction
    function automatic logic [31:0] get_meas(input int w);
        return (w == 0) ? if_a.meas_freq : if_b.meas_freq;
    endfunction
    function automatic logic get_ovf(input int w);
        return (w == 0) ? if_a.overflow : if_b.overflow;
    endfunction

    // Called at a negedge with the instance idle; n==1 uses start, n>1 uses cont
    // and drops it 50 cycles into the last gate.
    task automatic run_vec(input int idx, input int w, input int n,
                           input logic [31:0] exp_f, input logic exp_o);
        int t, vcount, busy_cnt, steps, drop_at;
        t = cyc; vcount = 0; busy_cnt = 0; steps = 0; drop_at = -1;
        if (n == 1) set_start(w, 1'b1); else set_cont(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        forever begin
            if (get_busy(w)) busy_cnt++;
            if (get_valid(w)) begin
                check($sformatf("v%0d_valid_time", idx), cyc, t + vcount * (int'(G_A) + 1) + int'(G_A) + 1);
                check($sformatf("v%0d_meas", idx), get_meas(w), exp_f);
                check($sformatf("v%0d_ovf", idx), get_ovf(w), exp_o);
                vcount++;
                if (vcount == n - 1) drop_at = cyc + 50;
            end
            if (cyc == drop_at) set_cont(w, 1'b0);
            if (!get_busy(w)) break;
            steps++;
            if (steps > n * (int'(G_A) + 1) + 20) begin
                fail_now($sformatf("v%0d_busy_timeout", idx));
                break;
            end
            @(negedge clk);
        end
        set_cont(w, 1'b0);
        check($sformatf("v%0d_result_count", idx), vcount, n);
        check($sformatf("v%0d_busy_cycles", idx), busy_cnt, n * (int'(G_A) + 1));
    endtask

    task automatic wait_idle_c();
        int steps;
        steps = 0;
        while (if_c.busy !== 1'b0 && steps < 200) begin
            @(negedge clk);
            steps++;
        end
        if (steps >= 200) fail_now("c_busy_timeout");
    endtask

    typedef struct {
        int          which;
        int          period;
        int          high;
        logic        level;
        int          n;
        logic [31:0] exp_f;
        logic        exp_o;
    } vec_t;
    vec_t vecs [9];

    initial begin : watchdog
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t, vcnt, vt, bcnt, n;

        // Window lengths are multiples of each period, so edge counts are exact.
        vecs[0] = '{0, 10,  5, 1'b0, 1, 32'd100,        1'b0};
        vecs[1] = '{0,  0,  0, 1'b0, 1, 32'd0,          1'b0};
        vecs[2] = '{0,  0,  0, 1'b1, 1, 32'd0,          1'b0};
        vecs[3] = '{0,  4,  2, 1'b0, 5, 32'd250,        1'b0};
        vecs[4] = '{0,  5,  1, 1'b0, 1, 32'd200,        1'b0};
        vecs[5] = '{0,  2,  1, 1'b0, 2, 32'd500,        1'b0};
        vecs[6] = '{1, 10,  5, 1'b0, 1, 32'hFFFF_FFFF,  1'b1};
        vecs[7] = '{1,  0,  0, 1'b0, 1, 32'd0,          1'b0};
        vecs[8] = '{0, 20, 13, 1'b0, 1, 32'd50,         1'b0};

        if_a.start = 1'b0; if_a.cont = 1'b0; if_a.f_in = 1'b0;
        if_b.start = 1'b0; if_b.cont = 1'b0; if_b.f_in = 1'b0;
        if_c.start = 1'b0; if_c.cont = 1'b0; if_c.f_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_meas_a", if_a.meas_freq, 32'd0);
        check("rst_valid_a", if_a.valid, 1'b0);
        check("rst_busy_a", if_a.busy, 1'b0);
        check("rst_ovf_a", if_a.overflow, 1'b0);
        check("rst_state_a", if_a.state, 2'd0);
        check("rst_busy_c", if_c.busy, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            gen_period = vecs[i].period;
            gen_high   = vecs[i].high;
            gen_level  = vecs[i].level;
            repeat (8) @(negedge clk);
            run_vec(i, vecs[i].which, vecs[i].n, vecs[i].exp_f, vecs[i].exp_o);
        end

        // Reset in the middle of a gate, with an extra start pulse beforehand.
        gen_period = 10; gen_high = 5;
        repeat (8) @(negedge clk);
        t = cyc;
        if_a.start = 1'b1; @(negedge clk); if_a.start = 1'b0;
        while (cyc < t + 30) @(negedge clk);
        if_a.start = 1'b1; @(negedge clk); if_a.start = 1'b0;
        while (cyc < t + 50) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("r5_meas", if_a.meas_freq, 32'd0);
        check("r5_valid", if_a.valid, 1'b0);
        check("r5_busy", if_a.busy, 1'b0);
        check("r5_ovf", if_a.overflow, 1'b0);
        vcnt = 0; bcnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (if_a.valid) vcnt++;
            if (if_a.busy) bcnt++;
        end
        check("r5_no_valid", vcnt, 0);
        check("r5_stays_idle", bcnt, 0);

        // A start during a running gate must not shift or repeat the result.
        t = cyc;
        if_a.start = 1'b1; @(negedge clk); if_a.start = 1'b0;
        while (cyc < t + 40) @(negedge clk);
        if_a.start = 1'b1; @(negedge clk); if_a.start = 1'b0;
        vcnt = 0; vt = -1;
        while (cyc < t + int'(G_A) + 1 + 150) begin
            if (if_a.valid) begin
                vcnt++;
                vt = cyc;
                check("ign_meas", if_a.meas_freq, 32'd100);
            end
            @(negedge clk);
        end
        check("ign_valid_count", vcnt, 1);
        check("ign_valid_time", vt, t + int'(G_A) + 1);

        for (int tr = 0; tr < 40; tr++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(2, 4);
                t = cyc;
                if_c.cont  = 1'b1;
                if_c.start = 1'($urandom_range(0, 1));
                for (int m = 0; m < n; m++) exp_q.push_back(32'(t + m * (int'(G_C) + 1)));
                @(negedge clk);
                if_c.start = 1'b0;
                while (cyc < t + (n - 1) * (int'(G_C) + 1) + 5) @(negedge clk);
                if_c.cont = 1'b0;
            end else begin
                t = cyc;
                if_c.start = 1'b1;
                exp_q.push_back(32'(t));
                @(negedge clk);
                if_c.start = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, int'(G_C) - 3)) @(negedge clk);
                    if_c.start = 1'b1; @(negedge clk); if_c.start = 1'b0;
                end
            end
            wait_idle_c();
        end
        repeat (3) @(negedge clk);
        check("c_pending_results", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
